// File: rtl/otter_mmio_pkg.sv
// otter_mmio_pkg: MMIO register offsets, decode select type and address decode helper
package otter_mmio_pkg;
  localparam logic [11:0] IRQ_PEND_OFS = 12'h100;
  localparam logic [11:0] IRQ_MASK_OFS = 12'h104;
  localparam int IN_STRIDE = 4;
  localparam int OUT_STRIDE = 32;
  typedef enum logic [2:0] {DEC_NONE, DEC_IN, DEC_OUT, DEC_PEND, DEC_MASK} mmio_sel_t;
  typedef struct packed {
    mmio_sel_t sel;
    logic [2:0] idx;
  } mmio_dec_t;
  function automatic mmio_dec_t mmio_decode(input logic [31:0] ofs, input int n_in, input int n_out);
    mmio_dec_t d;
    d.sel = DEC_NONE;
    d.idx = '0;
    if (ofs == {20'h0, IRQ_PEND_OFS}) d.sel = DEC_PEND;
    else if (ofs == {20'h0, IRQ_MASK_OFS}) d.sel = DEC_MASK;
    else if (ofs[1:0] == 2'b00 && ofs < 32'(IN_STRIDE * n_in)) begin
      d.sel = DEC_IN;
      d.idx = ofs[4:2];
    end else if (ofs[4:0] == 5'd0 && ofs >= 32'(OUT_STRIDE) && ofs < 32'(OUT_STRIDE * (n_out + 1))) begin
      d.sel = DEC_OUT;
      d.idx = ofs[7:5] - 3'd1;
    end
    return d;
  endfunction
endpackage

// File: rtl/mmio_debounce.sv
// mmio_debounce: 2-flop synchronizer, stability-count debouncer and rising-edge pulse
module mmio_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic CLK,
  input  logic RST,
  input  logic RAW,
  output logic DB_LEVEL,
  output logic RISE
);
  localparam int CW = $clog2(DB_CYCLES);
  logic s1, s2, lvl_d;
  logic [CW-1:0] cnt;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      lvl_d <= 1'b0;
      DB_LEVEL <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= RAW;
      s2 <= s1;
      lvl_d <= DB_LEVEL;
      if (s2 == DB_LEVEL) cnt <= '0;
      else if (cnt == CW'(DB_CYCLES - 1)) begin
        DB_LEVEL <= s2;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
  assign RISE = DB_LEVEL & ~lvl_d;
endmodule

// File: rtl/otter_mmio_ctrl.sv
// otter_mmio_ctrl: IOBUS MMIO decode with input/output ports and a debounced, maskable IRQ controller
module otter_mmio_ctrl
  import otter_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_AD = 32'h1100_0000,
  parameter int W = 16,
  parameter int N_IN = 2,
  parameter int N_OUT = 2,
  parameter int N_IRQ = 4,
  parameter int DB_CYCLES = 500000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [31:0]          IOBUS_ADDR,
  input  logic [31:0]          IOBUS_OUT,
  input  logic                 IOBUS_WR,
  output logic [31:0]          IOBUS_IN,
  input  logic [N_IN*W-1:0]    IN_PORTS,
  output logic [N_OUT*W-1:0]   OUT_PORTS,
  input  logic [N_IRQ-1:0]     BTN,
  output logic                 INTR
);
  mmio_dec_t dec;
  logic [N_IRQ-1:0] pend, mask, rise, db_level, w1c;
  assign dec = mmio_decode(IOBUS_ADDR - BASE_AD, N_IN, N_OUT);
  assign w1c = (IOBUS_WR && dec.sel == DEC_PEND) ? IOBUS_OUT[N_IRQ-1:0] : '0;
  for (genvar k = 0; k < N_IRQ; k++) begin : g_irq
    mmio_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .CLK(CLK),
      .RST(RST),
      .RAW(BTN[k]),
      .DB_LEVEL(db_level[k]),
      .RISE(rise[k])
    );
  end
  always_comb
    IOBUS_IN = dec.sel == DEC_IN   ? 32'(IN_PORTS[int'(dec.idx)*W +: W]) :
               dec.sel == DEC_OUT  ? 32'(OUT_PORTS[int'(dec.idx)*W +: W]) :
               dec.sel == DEC_PEND ? 32'(pend) :
               dec.sel == DEC_MASK ? 32'(mask) : 32'h0;
  // a new edge in the same cycle as its W1C must survive, so set is OR-ed after the clear
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      OUT_PORTS <= '0;
      pend <= '0;
      mask <= '0;
      INTR <= 1'b0;
    end else begin
      if (IOBUS_WR && dec.sel == DEC_OUT) OUT_PORTS[int'(dec.idx)*W +: W] <= IOBUS_OUT[W-1:0];
      if (IOBUS_WR && dec.sel == DEC_MASK) mask <= IOBUS_OUT[N_IRQ-1:0];
      pend <= (pend & ~w1c) | rise;
      INTR <= |(pend & mask);
    end
endmodule
